// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl -- fetch-stage PC owner and I-cache request sequencer.
//
// Owns the architectural fetch PC (pc_q). Each time the PC moves on, it
// issues one instruction request on the I-cache address/data handshake. It
// discards a response that a redirect has made stale. It presents the
// fetched {pc, inst} to decode through a single registered valid/ready slot.
//
// Ports:
//   clk, reset        core clock; asynchronous active-high reset
//   pc_selected       next PC from the fetch-stage selector
//   forward_pc_type   NO_FORWARD = sequential/predicted, PCW/PCM/PCI = redirect
//   pc_succ           pc_q + 4 back to the selector (wraps modulo 2^ADDR_W)
//   ireq_valid/addr   I-cache request (address = pc_q)
//   ireq_addr_ok      request accepted this cycle
//   iresp_data_ok     response valid this cycle, word on iresp_data
//   f_valid/pc/inst   decode slot; f_adel flags a misaligned PC
//   f_ready           decode accepts the slot

package pc_fetch_pkg;
  typedef enum logic [1:0] {
    NO_FORWARD = 2'd0,
    PCW        = 2'd1,
    PCM        = 2'd2,
    PCI        = 2'd3
  } forward_pc_type_t;
endpackage

module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_selected,
  input  forward_pc_type_t  forward_pc_type,
  output logic [ADDR_W-1:0] pc_succ,
  output logic              ireq_valid,
  output logic [ADDR_W-1:0] ireq_addr,
  input  logic              ireq_addr_ok,
  input  logic              iresp_data_ok,
  input  logic [31:0]       iresp_data,
  output logic              f_valid,
  output logic [ADDR_W-1:0] f_pc,
  output logic [31:0]       f_inst,
  output logic              f_adel,
  input  logic              f_ready
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc_q, pc_nxt;
  logic              drop, drop_nxt;
  logic              redirect;
  logic              advance;
  logic              misaligned;
  logic              slot_load;
  logic              slot_clear;

  assign redirect   = (forward_pc_type != NO_FORWARD);
  assign advance    = f_valid & f_ready;
  assign misaligned = (pc_q[1:0] != 2'b00);
  assign pc_succ    = pc_q + ADDR_W'(4);
  assign ireq_addr  = pc_q;

  always_comb begin
    state_nxt  = state;
    drop_nxt   = drop;
    pc_nxt     = pc_q;
    ireq_valid = 1'b0;
    slot_load  = 1'b0;
    slot_clear = 1'b0;

    // A redirect wins over a plain advance; both take the selector's PC.
    if (redirect || advance) begin
      pc_nxt = pc_selected;
    end

    case (state)
      S_REQ: begin
        if (misaligned) begin
          // No request for a misaligned PC; the slot carries the exception.
          // A redirect arriving now makes that exception stale, so stay here.
          if (!redirect) begin
            slot_load = 1'b1;
            state_nxt = S_HOLD;
          end
        end else begin
          // ireq_valid is masked during reset so every output is quiet then.
          ireq_valid = !reset;
          if (ireq_addr_ok) begin
            state_nxt = S_WAIT;
            // The accepted request is for the old PC; its answer is stale.
            if (redirect) begin
              drop_nxt = 1'b1;
            end
          end
        end
      end

      S_WAIT: begin
        if (iresp_data_ok) begin
          drop_nxt = 1'b0;
          if (drop || redirect) begin
            state_nxt = S_REQ;
          end else begin
            slot_load = 1'b1;
            state_nxt = S_HOLD;
          end
        end else if (redirect) begin
          // drop is a single bit; setting it again while set is a no-op.
          drop_nxt = 1'b1;
        end
      end

      S_HOLD: begin
        if (redirect || advance) begin
          slot_clear = 1'b1;
          state_nxt  = S_REQ;
        end
      end

      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  // Slot register boundary: state, PC and decode slot update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_REQ;
      pc_q    <= RESET_PC;
      drop    <= 1'b0;
      f_valid <= 1'b0;
      f_pc    <= '0;
      f_inst  <= '0;
      f_adel  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      drop  <= drop_nxt;
      if (slot_load) begin
        f_valid <= 1'b1;
        f_pc    <= pc_q;
        f_inst  <= misaligned ? 32'h0 : iresp_data;
        f_adel  <= misaligned;
      end else if (slot_clear) begin
        f_valid <= 1'b0;
      end
    end
  end

endmodule
